// File: rtl/monster_pkg.sv
// monster_pkg
//   Shared definitions for the monster movement logic and the collision probe
//   block: direction codes, coordinate widths and the legal screen bounds for
//   the monster's top-left corner (640x480 screen, 32x32 sprite).
package monster_pkg;

  localparam int DIR_W   = 2;
  localparam int COORD_W = 11;

  // Direction codes double as bit indices into the blocked-direction mask.
  typedef enum logic [DIR_W-1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  localparam int SCREEN_X_MIN = 0;
  localparam int SCREEN_X_MAX = 607;
  localparam int SCREEN_Y_MIN = 0;
  localparam int SCREEN_Y_MAX = 447;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'b00,
    ST_DECIDE  = 2'b01,
    ST_SEARCH  = 2'b10,
    ST_STEP    = 2'b11
  } state_t;

endpackage

// File: rtl/monster_dir_arbiter.sv
// monster_dir_arbiter
//   Combinational helper for the direction search: reports whether the
//   current candidate is free and produces the next candidate in rotation.
//   Ports:
//     i_mask   in  4  blocked-direction mask (bit index = direction code)
//     i_start  in  2  current candidate direction
//     o_next   out 2  candidate + 1 (mod 4)
//     o_free   out 1  1 = candidate not blocked
module monster_dir_arbiter
  import monster_pkg::*;
(
  input  logic [3:0] i_mask,
  input  dir_t       i_start,
  output dir_t       o_next,
  output logic       o_free
);

  // Two-bit add wraps naturally from UP back to RIGHT.
  assign o_next = dir_t'(i_start + 2'd1);
  assign o_free = ~i_mask[i_start];

endmodule

// File: rtl/monster_direction_ctrl.sv
// monster_direction_ctrl
//   Collects per-pixel blocked-direction reports from the collision probe over
//   a frame, picks a legal direction at each frame start and steps the
//   monster's top-left position.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     startOfFrame          one-cycle pulse per frame
//     enable                0 freezes motion (mask collection continues)
//     probe_hit, probe_dir  blocked-direction report from the probe block
//     random_move           LFSR bits seeding the direction search
//     topLeftX, topLeftY    monster position
//     cur_dir               current direction code
//     blocked_mask          mask latched at the last frame start
//     stuck                 all four directions blocked, monster holding
//     turn_pulse            one-cycle pulse when cur_dir changes
module monster_direction_ctrl
  import monster_pkg::*;
#(
  parameter int         INIT_X      = 288,
  parameter int         INIT_Y      = 224,
  parameter logic [1:0] INIT_DIR    = 2'b00,
  parameter int         SPEED       = 2,
  parameter int         TURN_PERIOD = 64,
  parameter int         X_MIN       = SCREEN_X_MIN,
  parameter int         X_MAX       = SCREEN_X_MAX,
  parameter int         Y_MIN       = SCREEN_Y_MIN,
  parameter int         Y_MAX       = SCREEN_Y_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        probe_hit,
  input  logic [1:0]  probe_dir,
  input  logic [1:0]  random_move,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  cur_dir,
  output logic [3:0]  blocked_mask,
  output logic        stuck,
  output logic        turn_pulse
);

  localparam int CNT_W = (TURN_PERIOD > 1) ? $clog2(TURN_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_PERIOD - 1);

  // Position arithmetic is done in 12-bit signed so LEFT/UP underflow below
  // zero is visible to the clamp instead of wrapping.
  localparam logic signed [11:0] SPEED_S = 12'(SPEED);
  localparam logic signed [11:0] X_MIN_S = 12'(X_MIN);
  localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
  localparam logic signed [11:0] Y_MIN_S = 12'(Y_MIN);
  localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);

  state_t             r_state;
  dir_t               r_dir;
  dir_t               r_cand;
  logic [1:0]         r_tries;
  logic [3:0]         r_acc;
  logic [3:0]         r_mask;
  logic [CNT_W-1:0]   r_fcnt;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_stuck;
  logic               r_turn;

  logic [3:0]         w_hit_vec;
  logic               w_repick;
  dir_t               w_next_cand;
  logic               w_cand_free;
  logic signed [11:0] w_x_sum;
  logic signed [11:0] w_y_sum;
  logic [COORD_W-1:0] w_x_new;
  logic [COORD_W-1:0] w_y_new;
  logic [3:0]         w_clamp_bits;

  assign w_hit_vec = probe_hit ? (4'b0001 << probe_dir) : 4'b0000;
  assign w_repick  = r_mask[r_dir] | (r_fcnt == CNT_LAST);

  monster_dir_arbiter u_arbiter (
    .i_mask  (r_mask),
    .i_start (r_cand),
    .o_next  (w_next_cand),
    .o_free  (w_cand_free)
  );

  // Next position with clamping; a clamp pre-blocks that direction so the
  // following frame turns away from the screen edge.
  always_comb begin
    w_x_sum      = $signed({1'b0, r_x});
    w_y_sum      = $signed({1'b0, r_y});
    w_clamp_bits = 4'b0000;
    case (r_dir)
      DIR_RIGHT: w_x_sum = $signed({1'b0, r_x}) + SPEED_S;
      DIR_LEFT:  w_x_sum = $signed({1'b0, r_x}) - SPEED_S;
      DIR_DOWN:  w_y_sum = $signed({1'b0, r_y}) + SPEED_S;
      default:   w_y_sum = $signed({1'b0, r_y}) - SPEED_S;
    endcase
    w_x_new = w_x_sum[COORD_W-1:0];
    w_y_new = w_y_sum[COORD_W-1:0];
    if (w_x_sum > X_MAX_S) begin
      w_x_new         = X_MAX_S[COORD_W-1:0];
      w_clamp_bits[0] = 1'b1;
    end else if (w_x_sum < X_MIN_S) begin
      w_x_new         = X_MIN_S[COORD_W-1:0];
      w_clamp_bits[1] = 1'b1;
    end
    if (w_y_sum > Y_MAX_S) begin
      w_y_new         = Y_MAX_S[COORD_W-1:0];
      w_clamp_bits[2] = 1'b1;
    end else if (w_y_sum < Y_MIN_S) begin
      w_y_new         = Y_MIN_S[COORD_W-1:0];
      w_clamp_bits[3] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_COLLECT;
      r_dir   <= dir_t'(INIT_DIR);
      r_cand  <= DIR_RIGHT;
      r_tries <= 2'd0;
      r_acc   <= 4'b0000;
      r_mask  <= 4'b0000;
      r_fcnt  <= '0;
      r_x     <= COORD_W'(INIT_X);
      r_y     <= COORD_W'(INIT_Y);
      r_stuck <= 1'b0;
      r_turn  <= 1'b0;
    end else begin
      r_turn <= 1'b0;
      // Hits outside the frame-start cycle always accumulate for the next frame.
      r_acc  <= r_acc | w_hit_vec;
      case (r_state)
        ST_COLLECT: begin
          if (startOfFrame) begin
            // A hit in the SOF cycle still belongs to the frame that is ending.
            r_mask <= r_acc | w_hit_vec;
            r_acc  <= 4'b0000;
            if (enable) r_state <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          r_fcnt <= (r_fcnt == CNT_LAST) ? '0 : r_fcnt + 1'b1;
          if (w_repick) begin
            r_cand  <= dir_t'(random_move);
            r_tries <= 2'd0;
            r_state <= ST_SEARCH;
          end else begin
            r_state <= ST_STEP;
          end
        end
        ST_SEARCH: begin
          if (w_cand_free) begin
            r_turn  <= (r_cand != r_dir);
            r_dir   <= r_cand;
            r_state <= ST_STEP;
          end else begin
            r_cand  <= w_next_cand;
            r_tries <= r_tries + 2'd1;
            if (r_tries == 2'd3) begin
              r_stuck <= 1'b1;
              r_state <= ST_COLLECT;
            end
          end
        end
        ST_STEP: begin
          r_stuck <= 1'b0;
          r_x     <= w_x_new;
          r_y     <= w_y_new;
          r_acc   <= r_acc | w_hit_vec | w_clamp_bits;
          r_state <= ST_COLLECT;
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign topLeftX     = r_x;
  assign topLeftY     = r_y;
  assign cur_dir      = r_dir;
  assign blocked_mask = r_mask;
  assign stuck        = r_stuck;
  assign turn_pulse   = r_turn;

endmodule

// File: tb/tb_monster_direction_ctrl.sv
module tb_monster_direction_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sof = 1'b0;
  logic        enable = 1'b1;
  logic        probe_hit = 1'b0;
  logic [1:0]  probe_dir = 2'b00;
  logic [1:0]  random_move = 2'b00;

  logic [10:0] a_x, a_y, b_x, b_y;
  logic [1:0]  a_dir, b_dir;
  logic [3:0]  a_mask, b_mask;
  logic        a_stuck, b_stuck, a_turn, b_turn;

  int total = 0;
  int bad = 0;
  int turns_a = 0;
  int turns_b = 0;
  int frame_no = 0;

  always #5 clk = ~clk;

  // Default-parameter instance.
  monster_direction_ctrl dut_a (
    .clk(clk), .reset(reset), .startOfFrame(sof), .enable(enable),
    .probe_hit(probe_hit), .probe_dir(probe_dir), .random_move(random_move),
    .topLeftX(a_x), .topLeftY(a_y), .cur_dir(a_dir), .blocked_mask(a_mask),
    .stuck(a_stuck), .turn_pulse(a_turn)
  );

  // Starts next to the right edge and re-picks every 4th frame.
  monster_direction_ctrl #(.INIT_X(606), .TURN_PERIOD(4)) dut_b (
    .clk(clk), .reset(reset), .startOfFrame(sof), .enable(enable),
    .probe_hit(probe_hit), .probe_dir(probe_dir), .random_move(random_move),
    .topLeftX(b_x), .topLeftY(b_y), .cur_dir(b_dir), .blocked_mask(b_mask),
    .stuck(b_stuck), .turn_pulse(b_turn)
  );

  // Counts high cycles of turn_pulse, so a stretched pulse shows up too.
  always @(negedge clk) begin
    if (a_turn) turns_a++;
    if (b_turn) turns_b++;
  end

  typedef struct {
    int         x;
    int         y;
    int         dir;
    logic [3:0] mask;
    logic [3:0] acc;
    int         fcnt;
    int         stuck;
    int         turns;
    int         tp;
  } mdl_t;

  mdl_t m [2];
  mdl_t exp_q [$];

  function automatic mdl_t mdl_reset(int ix, int tp, int turns);
    mdl_t s;
    s.x = ix; s.y = 224; s.dir = 0; s.mask = 4'b0; s.acc = 4'b0;
    s.fcnt = 0; s.stuck = 0; s.turns = turns; s.tp = tp;
    return s;
  endfunction

  // One frame boundary: latch mask, decide, search, step, clamp.
  function automatic mdl_t mdl_frame(mdl_t s_in, logic [3:0] hits, logic [1:0] rnd, bit en);
    mdl_t s;
    logic [1:0] c;
    bit found;
    bit rep;
    s = s_in;
    s.mask = s.acc | hits;
    s.acc  = 4'b0;
    if (!en) return s;
    rep = s.mask[s.dir] || (s.fcnt == s.tp - 1);
    s.fcnt = (s.fcnt == s.tp - 1) ? 0 : s.fcnt + 1;
    if (rep) begin
      c = rnd;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!found) begin
          if (!s.mask[c]) found = 1'b1;
          else c = c + 2'd1;
        end
      end
      if (!found) begin
        s.stuck = 1;
        return s;
      end
      if (int'(c) != s.dir) s.turns++;
      s.dir = int'(c);
    end
    s.stuck = 0;
    case (s.dir)
      0:       s.x += 2;
      1:       s.x -= 2;
      2:       s.y += 2;
      default: s.y -= 2;
    endcase
    if (s.x > 607) begin s.x = 607; s.acc[0] = 1'b1; end
    if (s.x < 0)   begin s.x = 0;   s.acc[1] = 1'b1; end
    if (s.y > 447) begin s.y = 447; s.acc[2] = 1'b1; end
    if (s.y < 0)   begin s.y = 0;   s.acc[3] = 1'b1; end
    return s;
  endfunction

  task automatic check(string tag, int obs, int exp_v);
    total++;
    if (obs != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic compare_dut(string who, mdl_t e, int x, int y, int dir, int mask,
                             int stk, int turns);
    check({who, "_x"}, x, e.x);
    check({who, "_y"}, y, e.y);
    check({who, "_dir"}, dir, e.dir);
    check({who, "_mask"}, mask, int'(e.mask));
    check({who, "_stuck"}, stk, e.stuck);
    check({who, "_turns"}, turns, e.turns);
  endtask

  task automatic check_reset_values(string who);
    check({who, "_rst_ax"}, int'(a_x), 288);
    check({who, "_rst_bx"}, int'(b_x), 606);
    check({who, "_rst_ay"}, int'(a_y), 224);
    check({who, "_rst_dir"}, int'(a_dir) + int'(b_dir), 0);
    check({who, "_rst_mask"}, int'(a_mask) + int'(b_mask), 0);
    check({who, "_rst_stuck"}, int'(a_stuck) + int'(b_stuck), 0);
    check({who, "_rst_turn"}, int'(a_turn) + int'(b_turn), 0);
  endtask

  task automatic model_reset();
    m[0] = mdl_reset(288, 64, m[0].turns);
    m[1] = mdl_reset(606, 4, m[1].turns);
  endtask

  // Hits during the frame (one cycle per set bit), optional hit in the SOF
  // cycle, then the SOF pulse; results are compared 6 cycles after SOF.
  task automatic run_frame(input logic [3:0] hits, input bit sof_hit,
                           input logic [1:0] sof_dir, input logic [1:0] rnd, input bit en);
    logic [3:0] all_hits;
    mdl_t ea, eb;
    for (int k = 0; k < 4; k++) begin
      if (hits[k]) begin
        @(negedge clk);
        probe_hit = 1'b1;
        probe_dir = 2'(k);
      end
    end
    @(negedge clk);
    probe_hit = 1'b0;
    @(negedge clk);
    sof = 1'b1;
    random_move = rnd;
    enable = en;
    probe_hit = sof_hit;
    probe_dir = sof_dir;
    all_hits = hits | (sof_hit ? (4'b0001 << sof_dir) : 4'b0000);
    for (int i = 0; i < 2; i++) begin
      m[i] = mdl_frame(m[i], all_hits, rnd, en);
      exp_q.push_back(m[i]);
    end
    @(negedge clk);
    sof = 1'b0;
    probe_hit = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    ea = exp_q.pop_front();
    eb = exp_q.pop_front();
    compare_dut("a", ea, int'(a_x), int'(a_y), int'(a_dir), int'(a_mask), int'(a_stuck), turns_a);
    compare_dut("b", eb, int'(b_x), int'(b_y), int'(b_dir), int'(b_mask), int'(b_stuck), turns_b);
    frame_no++;
    $display("frame %0d hits=%b rnd=%0d en=%0d | a x=%0d y=%0d dir=%0d mask=%b stuck=%0d | b x=%0d y=%0d dir=%0d mask=%b stuck=%0d",
             frame_no, all_hits, rnd, en, a_x, a_y, a_dir, a_mask, a_stuck,
             b_x, b_y, b_dir, b_mask, b_stuck);
    @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m[0] = mdl_reset(288, 64, 0);
    m[1] = mdl_reset(606, 4, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("init");

    // Free motion, no walls; dut_b clamps at the edge and turns away.
    for (int f = 0; f < 3; f++) run_frame(4'b0000, 1'b0, 2'b00, 2'b01, 1'b1);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_reset_values("rst2");

    run_frame(4'b0001, 1'b0, 2'b00, 2'b01, 1'b1);   // blocked RIGHT -> LEFT
    run_frame(4'b1011, 1'b0, 2'b00, 2'b00, 1'b1);   // search lands on DOWN
    run_frame(4'b1111, 1'b0, 2'b00, 2'b10, 1'b1);   // fully boxed in
    run_frame(4'b0000, 1'b0, 2'b00, 2'b00, 1'b1);   // released
    run_frame(4'b0100, 1'b0, 2'b00, 2'b01, 1'b0);   // frozen, mask still latched
    run_frame(4'b0000, 1'b0, 2'b00, 2'b01, 1'b1);
    run_frame(4'b0000, 1'b1, 2'b10, 2'b11, 1'b1);   // hit in the SOF cycle

    // Reset while both instances are searching.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      probe_hit = 1'b1;
      probe_dir = 2'(k);
    end
    @(negedge clk);
    probe_hit = 1'b0;
    @(negedge clk);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("search_rst");
    $display("reset during search: a x=%0d dir=%0d | b x=%0d dir=%0d", a_x, a_dir, b_x, b_dir);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    run_frame(4'b0000, 1'b0, 2'b00, 2'b00, 1'b1);
    for (int f = 0; f < 6; f++) run_frame(4'b0000, 1'b0, 2'b00, 2'(f + 1), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
